move_scheduler: RTL and testbench
=================================

MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter DEPTH, default 4: move queue depth in entries.
REQ-002 Parameter TIMEOUT, default 255: max cycles to wait for mv_done.
REQ-003 Parameter START_WIN, default 8: max cycles to wait for drawer to go busy after redraw.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 move_valid  in  1  move request from user input.
REQ-007 move_code  in  4  move id 0-11 (face*2 + dir); 12-15 invalid.
REQ-008 move_ready  out  1  queue can accept a move this cycle.
REQ-009 refresh  in  1  request a redraw without a move.
REQ-010 mv_start  out  1  one-cycle command to the cube logic to apply mv_code.
REQ-011 mv_code  out  4  move id presented with mv_start.
REQ-012 mv_done  in  1  cube logic has finished applying the move.
REQ-013 redraw  out  1  one-cycle redraw request to the cube drawer.
REQ-014 draw_busy  in  1  drawer is plotting (its plot output).
REQ-015 busy  out  1  high whenever the state is not IDLE.
REQ-016 pending  out  3  number of queued moves, 0..DEPTH.
REQ-017 err_timeout  out  1  sticky: some move never returned mv_done.

Function
REQ-018 The queue SHALL be a FIFO of DEPTH x 4 bits with registered count; move_ready = (count < DEPTH), derived from the registered count.
REQ-019 A push SHALL occur on an edge where move_valid && move_ready and move_code <= 11; codes 12-15 are dropped silently.
REQ-020 When full, move_ready SHALL be 0 even if a pop occurs in the same cycle; push and pop in the same cycle below full SHALL leave count unchanged.
REQ-021 States SHALL be IDLE, ISSUE, WAIT_MOVE, REDRAW, WAIT_DRAW_START, WAIT_DRAW_END.
REQ-022 IDLE: if count > 0 go to ISSUE; else if refresh_pend go to REDRAW; else stay.
REQ-023 ISSUE (1 cycle): mv_start = 1; mv_code = FIFO head; pop on exit; clear timer; go to WAIT_MOVE.
REQ-024 mv_start and redraw SHALL be Moore outputs, high only during ISSUE and REDRAW respectively; mv_code SHALL hold its last issued value otherwise.
REQ-025 WAIT_MOVE: on mv_done go to REDRAW. If the timer reaches TIMEOUT-1 without mv_done, set err_timeout and go to REDRAW. mv_done in any other state SHALL be ignored.
REQ-026 REDRAW (1 cycle): redraw = 1; clear refresh_pend; clear timer; go to WAIT_DRAW_START.
REQ-027 WAIT_DRAW_START: on draw_busy = 1 go to WAIT_DRAW_END. If draw_busy is not seen within START_WIN cycles, go to IDLE.
REQ-028 WAIT_DRAW_END: on draw_busy = 0 go to IDLE.
REQ-029 Moves SHALL never be issued while the drawer is busy; exactly one redraw SHALL follow each issued move.
REQ-030 A refresh pulse in any state SHALL set refresh_pend. A refresh in the same cycle as REDRAW SHALL remain pending. A pending refresh SHALL be satisfied by the next REDRAW, whether that REDRAW was triggered by a move or by the refresh.
REQ-031 Latency: a move accepted at edge t with state IDLE and an empty queue SHALL produce mv_start = 1 in the cycle after edge t+1.
REQ-032 The timer SHALL be 8 bits, saturating, and count only in WAIT_MOVE and WAIT_DRAW_START.

Reset
REQ-033 On reset = 1 at a clock edge:
- state = IDLE, count = 0, FIFO pointers = 0, refresh_pend = 0, timer = 0
- outputs: mv_start = 0, redraw = 0, mv_code = 0, busy = 0, pending = 0, err_timeout = 0, move_ready = 1
REQ-034 Reset mid-operation SHALL discard all queued moves and any pending refresh. It SHALL take priority over a simultaneous move_valid or refresh.

Verification
REQ-035 Single move: push code 5 into an idle, empty block -> mv_start for 1 cycle with mv_code = 5 one cycle after acceptance. Then mv_done -> redraw pulse; draw_busy high 3 cycles then low -> busy returns to 0.
REQ-036 Fill and backpressure: push 6 moves (0..5) back-to-back while mv_done is held off -> move_ready = 0 once full. Exactly 5 are accepted (4 queued + 1 popped), pending peaks at 4, and moves are issued in order 0..4.
REQ-037 Timeout: issue a move and never assert mv_done -> err_timeout = 1 after 255 cycles in WAIT_MOVE, and redraw is still pulsed. err_timeout stays 1 until reset.
REQ-038 Refresh: refresh pulse while idle with an empty queue -> redraw with no mv_start. A refresh during WAIT_DRAW_END with an empty queue -> exactly one further redraw.
REQ-039 Drawer silent: draw_busy held at 0 after redraw -> return to IDLE after 8 cycles. Invalid code 13 pushed -> pending unchanged.
REQ-040 Reset in WAIT_MOVE with 3 moves queued -> pending = 0, busy = 0, and a later mv_done causes no redraw.

Source files
------------

// File: rtl/move_scheduler.sv
// Purpose: serialises user moves to the cube logic and follows each with one drawer redraw.
// Latency: a move accepted into an idle, empty queue is issued (mv_start) in the cycle after the next edge.
// Backpressure: move_ready drops while the queue holds DEPTH moves; codes 12-15 are dropped silently.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   move_valid/move_code  move request in (code 0-11), move_ready = queue has room
//   refresh               redraw request without a move (remembered until a redraw runs)
//   mv_start/mv_code      one-cycle apply command to the cube logic, mv_done = move applied
//   redraw/draw_busy      one-cycle redraw command to the drawer, draw_busy = drawer plotting
//   busy, pending         scheduler not idle, number of queued moves
//   err_timeout           sticky: a move never came back with mv_done

// Purpose: generic synchronous FIFO with registered occupancy count.
// Latency: pushed data is visible at head_dat after the push edge.
// Backpressure: push_rdy comes from the registered count only, so a full FIFO refuses a push even when popped.
module fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign push_rdy = (count < CW'(DEPTH));
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop && (count != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module move_scheduler #(
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 255,
    parameter int START_WIN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_valid,
    input  logic [3:0] move_code,
    output logic       move_ready,
    input  logic       refresh,
    output logic       mv_start,
    output logic [3:0] mv_code,
    input  logic       mv_done,
    output logic       redraw,
    input  logic       draw_busy,
    output logic       busy,
    output logic [2:0] pending,
    output logic       err_timeout
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_MOVE,
        REDRAW,
        WAIT_DRAW_START,
        WAIT_DRAW_END
    } state_t;

    state_t        state;
    logic [7:0]    timer;
    logic          refresh_pend;
    logic [CW-1:0] q_count;
    logic [3:0]    q_head;
    logic          q_push;
    logic          q_pop;

    // Codes above 11 are not real moves; they never enter the queue.
    assign q_push  = move_valid && (move_code <= 4'd11);
    // ISSUE always lasts exactly one cycle, so popping throughout it pops once on exit.
    assign q_pop   = (state == ISSUE);
    assign pending = 3'(q_count);

    fifo #(
        .DEPTH (DEPTH),
        .WIDTH (4)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .push_vld (q_push),
        .push_dat (move_code),
        .push_rdy (move_ready),
        .pop      (q_pop),
        .head_dat (q_head),
        .count    (q_count)
    );

    // mv_start, redraw and busy are registered alongside the state so they
    // always equal the decode of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            refresh_pend <= 1'b0;
            mv_start     <= 1'b0;
            mv_code      <= '0;
            redraw       <= 1'b0;
            busy         <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            mv_start <= 1'b0;
            redraw   <= 1'b0;
            if (refresh) begin
                refresh_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // Holding off while the drawer is still plotting keeps a
                    // late draw_busy from overlapping a move.
                    if ((q_count != '0) && !draw_busy) begin
                        state    <= ISSUE;
                        mv_start <= 1'b1;
                        mv_code  <= q_head;
                        busy     <= 1'b1;
                    end else if (refresh_pend) begin
                        state  <= REDRAW;
                        redraw <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT_MOVE;
                end
                WAIT_MOVE: begin
                    if (mv_done || (timer == 8'(TIMEOUT - 1))) begin
                        if (!mv_done) begin
                            err_timeout <= 1'b1;
                        end
                        state  <= REDRAW;
                        redraw <= 1'b1;
                    end else if (timer != 8'hFF) begin
                        timer <= timer + 8'd1;
                    end
                end
                REDRAW: begin
                    // This redraw satisfies any earlier refresh; one arriving
                    // in this very cycle still needs its own redraw.
                    refresh_pend <= refresh;
                    timer        <= '0;
                    state        <= WAIT_DRAW_START;
                end
                WAIT_DRAW_START: begin
                    if (draw_busy) begin
                        state <= WAIT_DRAW_END;
                    end else if (timer == 8'(START_WIN - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (timer != 8'hFF) begin
                        timer <= timer + 8'd1;
                    end
                end
                WAIT_DRAW_END: begin
                    if (!draw_busy) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_move_scheduler.sv
// Purpose: self-checking bench for move_scheduler with a cube/drawer responder and move scoreboard.
// Latency: all stimulus and sampling happen on the falling clock edge.
// Backpressure: the bench drives move_valid regardless of move_ready and models acceptance itself.
module tb_move_scheduler;
    logic       clk = 1'b0;
    logic       reset;
    logic       move_valid;
    logic [3:0] move_code;
    logic       move_ready;
    logic       refresh;
    logic       mv_start;
    logic [3:0] mv_code;
    logic       mv_done;
    logic       redraw;
    logic       draw_busy;
    logic       busy;
    logic [2:0] pending;
    logic       err_timeout;

    always #5 clk = ~clk;

    move_scheduler #(
        .DEPTH     (4),
        .TIMEOUT   (255),
        .START_WIN (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .move_valid  (move_valid),
        .move_code   (move_code),
        .move_ready  (move_ready),
        .refresh     (refresh),
        .mv_start    (mv_start),
        .mv_code     (mv_code),
        .mv_done     (mv_done),
        .redraw      (redraw),
        .draw_busy   (draw_busy),
        .busy        (busy),
        .pending     (pending),
        .err_timeout (err_timeout)
    );

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_start = 0;
    int n_redraw = 0;

    // Moves expected to be issued, in order.
    logic [3:0] sb[$];

    // Responder controls.
    bit auto_done  = 1'b0;
    bit extra_done = 1'b0;
    bit start_seen = 1'b0;
    int busy_len   = 3;
    int busy_left  = 0;

    typedef struct {
        logic [3:0] code;
        bit         accept;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: observe outputs, score issued moves, then play the cube
    // logic (mv_done one cycle after mv_start) and the drawer (busy for
    // busy_len cycles starting with the redraw pulse).
    task automatic step();
        logic [3:0] e;
        @(negedge clk);
        if (mv_start) begin
            n_start++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_mv_start: got code %0d, expected no issue", mv_code);
            end else begin
                e = sb.pop_front();
                check("mv_code", 32'(mv_code), 32'(e));
            end
            check("no_issue_while_drawing", 32'(draw_busy), 0);
        end
        if (redraw) n_redraw++;
        mv_done    = (auto_done && start_seen) || extra_done;
        start_seen = mv_start;
        if (redraw) busy_left = busy_len;
        draw_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!(busy == 1'b0 && pending == 3'd0) && k < budget) begin
            step();
            k++;
        end
        check("idle_reached", 32'(busy == 1'b0 && pending == 3'd0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    initial begin
        int s0;
        int r0;
        int cnt;
        int peak;

        vecs[0] = '{4'd5,  1'b1};
        vecs[1] = '{4'd0,  1'b1};
        vecs[2] = '{4'd11, 1'b1};
        vecs[3] = '{4'd12, 1'b0};
        vecs[4] = '{4'd13, 1'b0};
        vecs[5] = '{4'd15, 1'b0};

        reset      = 1'b1;
        move_valid = 1'b0;
        move_code  = 4'd0;
        refresh    = 1'b0;
        mv_done    = 1'b0;
        draw_busy  = 1'b0;
        run(3);
        reset = 1'b0;

        // Reset state.
        check("rst_mv_start", 32'(mv_start), 0);
        check("rst_redraw", 32'(redraw), 0);
        check("rst_mv_code", 32'(mv_code), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_err", 32'(err_timeout), 0);
        check("rst_ready", 32'(move_ready), 1);

        // Single moves from idle, valid and invalid codes.
        auto_done = 1'b1;
        busy_len  = 3;
        for (int i = 0; i < 6; i++) begin
            s0 = n_start;
            r0 = n_redraw;
            move_valid = 1'b1;
            move_code  = vecs[i].code;
            if (vecs[i].accept) sb.push_back(vecs[i].code);
            step();
            move_valid = 1'b0;
            check("pending_after_push", 32'(pending), 32'(vecs[i].accept));
            check("no_early_start", 32'(mv_start), 0);
            step();
            check("start_latency", 32'(mv_start), 32'(vecs[i].accept));
            if (vecs[i].accept) begin
                step();
                check("busy_in_wait_move", 32'(busy), 1);
                step();
                check("redraw_after_done", 32'(redraw), 1);
            end else begin
                check("invalid_stays_idle", 32'(busy), 0);
            end
            wait_idle(50);
            check("starts_per_vec", 32'(n_start - s0), 32'(vecs[i].accept));
            check("redraws_per_vec", 32'(n_redraw - r0), 32'(vecs[i].accept));
        end

        // Fill and backpressure: six back-to-back moves with mv_done held off.
        auto_done = 1'b0;
        s0   = n_start;
        r0   = n_redraw;
        peak = 0;
        for (int i = 0; i < 6; i++) begin
            move_valid = 1'b1;
            move_code  = 4'(i);
            if (i < 5) sb.push_back(4'(i));
            step();
            if (int'(pending) > peak) peak = int'(pending);
        end
        move_valid = 1'b0;
        check("full_ready_low", 32'(move_ready), 0);
        check("full_pending", 32'(pending), 4);
        check("pending_peak", 32'(peak), 4);
        extra_done = 1'b1;
        step();
        extra_done = 1'b0;
        auto_done  = 1'b1;
        wait_idle(300);
        check("fill_starts", 32'(n_start - s0), 5);
        check("fill_redraws", 32'(n_redraw - r0), 5);
        check("fill_sb_empty", 32'(sb.size()), 0);

        // Timeout: mv_done never comes.
        auto_done = 1'b0;
        busy_len  = 1;
        move_valid = 1'b1;
        move_code  = 4'd7;
        sb.push_back(4'd7);
        step();
        move_valid = 1'b0;
        step();
        check("timeout_start", 32'(mv_start), 1);
        cnt = 0;
        do begin
            step();
            cnt++;
            if (cnt == 255) check("no_err_early", 32'(err_timeout), 0);
        end while (!redraw && cnt < 300);
        // 255 cycles in WAIT_MOVE, redraw on the next negedge.
        check("timeout_cycles", 32'(cnt), 256);
        check("timeout_err", 32'(err_timeout), 1);
        wait_idle(50);
        check("err_sticky", 32'(err_timeout), 1);
        auto_done = 1'b1;
        busy_len  = 3;

        // Refresh while idle with an empty queue.
        s0 = n_start;
        r0 = n_redraw;
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        step();
        check("refresh_redraw", 32'(redraw), 1);
        wait_idle(50);
        check("refresh_redraws", 32'(n_redraw - r0), 1);
        check("refresh_no_start", 32'(n_start - s0), 0);

        // Refresh during WAIT_DRAW_END: exactly one further redraw.
        busy_len = 4;
        r0 = n_redraw;
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        run(3);
        check("in_draw_busy", 32'(busy), 1);
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        run(30);
        check("refresh_in_draw_redraws", 32'(n_redraw - r0), 2);

        // Refresh in the REDRAW cycle itself stays pending.
        busy_len = 3;
        r0 = n_redraw;
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        step();
        check("redraw_cycle", 32'(redraw), 1);
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        run(30);
        check("refresh_in_redraw_redraws", 32'(n_redraw - r0), 2);

        // Drawer silent: 8 cycles in WAIT_DRAW_START then idle.
        busy_len = 0;
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        step();
        check("silent_redraw", 32'(redraw), 1);
        cnt = 0;
        do begin
            step();
            cnt++;
            if (cnt == 8) check("silent_still_busy", 32'(busy), 1);
        end while (busy && cnt < 20);
        check("silent_cycles", 32'(cnt), 9);
        busy_len = 3;

        // Reset in WAIT_MOVE with three moves queued and a refresh pending.
        auto_done = 1'b0;
        s0 = n_start;
        r0 = n_redraw;
        for (int i = 1; i <= 4; i++) begin
            move_valid = 1'b1;
            move_code  = 4'(i);
            sb.push_back(4'(i));
            step();
        end
        move_valid = 1'b0;
        check("queued_before_reset", 32'(pending), 3);
        check("busy_before_reset", 32'(busy), 1);
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        reset      = 1'b1;
        move_valid = 1'b1;
        move_code  = 4'd9;
        refresh    = 1'b1;
        step();
        reset      = 1'b0;
        move_valid = 1'b0;
        refresh    = 1'b0;
        sb.delete();
        check("reset_pending", 32'(pending), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_err_clear", 32'(err_timeout), 0);
        check("reset_ready", 32'(move_ready), 1);
        check("reset_mv_code", 32'(mv_code), 0);
        extra_done = 1'b1;
        step();
        extra_done = 1'b0;
        run(10);
        check("reset_no_redraw", 32'(n_redraw - r0), 0);
        check("reset_starts", 32'(n_start - s0), 1);
        check("reset_still_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
